// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// mux_pkg : shared channel-count constants and select decode for the mux path
// Rev 1.0 : initial release
// ============================================================================
package mux_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  function automatic logic [N_CH-1:0] chan_onehot(input logic [SEL_W-1:0] sel);
    logic [N_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// demux_slot : one-entry output holding register with same-cycle pass-through
// Rev 1.0 : initial release
// ============================================================================
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // A load in the same cycle as a drain keeps the slot full with the new word.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign free  = ~valid_q | ready;

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux_1x8_reg.sv
`default_nettype none
// ============================================================================
// demux_1x8_reg : registered 1-to-8 demultiplexer with broadcast and
//                 per-channel one-entry holding registers
// Rev 1.0 : initial release
// ============================================================================
module demux_1x8_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  bcast,
  input  logic [SEL_W-1:0]      select,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready
);

  logic [N_CH-1:0] w_free;
  logic [N_CH-1:0] w_load;
  logic            w_accept;

  // Broadcast needs every channel able to take the word in the same cycle.
  always_comb begin
    in_ready = 1'b0;
    if (en) begin
      in_ready = bcast ? (&w_free) : w_free[select];
    end
  end

  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_load = '0;
    if (w_accept) begin
      w_load = bcast ? {N_CH{1'b1}} : chan_onehot(select);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (w_load[k]),
      .in_data (in_data),
      .ready   (out_ready[k]),
      .valid   (out_valid[k]),
      .data    (out_data[k*WIDTH +: WIDTH]),
      .free    (w_free[k])
    );
  end

endmodule : demux_1x8_reg
`default_nettype wire
